pll_sweep_sequencer: RTL

Steps the RF ADF4351 through a fractional-N frequency sweep after the init register set has been loaded. It issues one REG0 write per step to the existing ADF4351 SPI serializer, then waits a settling time and for PLL lock. It then opens a dwell window for the ADC capture path. It sits between host control (start/stop, sweep setup) and the ADF4351 serializer's wen/wdata/done handshake.

---
 rtl/adf_pkg.sv | 37 +++
 rtl/pll_sweep_sequencer_if.sv | 9 +
 rtl/sync_2ff.sv | 26 ++
 rtl/pll_sweep_sequencer.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/adf_pkg.sv
// Shared ADF4351 definitions: sweep FSM states, REG0 field layout and register addresses.
// Also used by the init-register sequencer.
package adf_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WRITE,
    S_WAIT_DONE,
    S_SETTLE,
    S_WAIT_LOCK,
    S_DWELL,
    S_NEXT
  } sweep_state_t;

  // The low three bits of every ADF4351 word carry the register address.
  typedef enum logic [2:0] {
    ADF_R0 = 3'd0,
    ADF_R1 = 3'd1,
    ADF_R2 = 3'd2,
    ADF_R3 = 3'd3,
    ADF_R4 = 3'd4,
    ADF_R5 = 3'd5
  } adf_addr_t;

  localparam int         INT_W     = 16;
  localparam int         FRAC_W    = 12;
  localparam int         INT_LSB   = 15;
  localparam int         FRAC_LSB  = 3;
  localparam logic [2:0] REG0_CTRL = 3'b000;

  function automatic logic [31:0] reg0_word(input logic [INT_W-1:0]  int_val,
                                            input logic [FRAC_W-1:0] frac_val);
    return (32'(int_val) << INT_LSB) | (32'(frac_val) << FRAC_LSB) | 32'(REG0_CTRL);
  endfunction

endpackage

// File: rtl/pll_sweep_sequencer_if.sv
// Write handshake between the sweep sequencer and the ADF4351 SPI serializer.
interface pll_sweep_sequencer_if;
  logic        adf_wen;
  logic [31:0] adf_wdata;
  logic        adf_done;

  modport master (output adf_wen, output adf_wdata, input adf_done);
  modport slave  (input adf_wen, input adf_wdata, output adf_done);
endinterface

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer for asynchronous level inputs.
module sync_2ff #(
  parameter int DATA_W = 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);

  logic [DATA_W-1:0] meta_p0;
  logic [DATA_W-1:0] sync_p1;

  always_ff @(posedge CLK) begin
    if (RST) begin
      meta_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      meta_p0 <= d;
      sync_p1 <= meta_p0;
    end
  end

  assign q = sync_p1;

endmodule

// File: rtl/pll_sweep_sequencer.sv
// Fractional-N frequency sweep for the ADF4351: one REG0 write per step, settle,
// wait for lock, then a dwell window for the ADC capture path.
module pll_sweep_sequencer
  import adf_pkg::*;
#(
  parameter int N_STEPS      = 16,
  parameter int SETTLE_CYC   = 4000,
  parameter int LOCK_TIMEOUT = 40000,
  parameter int DWELL_CYC    = 40000,
  parameter int IDX_W        = 8
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     start,
  input  logic                     stop,
  input  logic                     continuous,
  input  logic [INT_W-1:0]         base_int,
  input  logic [FRAC_W-1:0]        base_frac,
  input  logic [FRAC_W-1:0]        step_frac,
  input  logic [FRAC_W-1:0]        mod,
  pll_sweep_sequencer_if.master    adf,
  input  logic                     lock_det,
  output logic                     busy,
  output logic                     dwell,
  output logic [IDX_W-1:0]         step_idx,
  output logic                     lock_err,
  output logic                     sweep_done
);

  localparam int CNT_MAX0 = (SETTLE_CYC > LOCK_TIMEOUT) ? SETTLE_CYC : LOCK_TIMEOUT;
  localparam int CNT_MAX  = (CNT_MAX0 > DWELL_CYC) ? CNT_MAX0 : DWELL_CYC;
  localparam int CNT_W    = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0] SETTLE_LD  = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LD = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] DWELL_LD   = CNT_W'(DWELL_CYC - 1);
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(N_STEPS - 1);

  // Advance FRAC by one step; a carry past MOD rolls into INT (16-bit wrap).
  function automatic logic [INT_W+FRAC_W-1:0] next_freq(input logic [INT_W-1:0]  int_val,
                                                        input logic [FRAC_W-1:0] frac_val,
                                                        input logic [FRAC_W-1:0] inc,
                                                        input logic [FRAC_W-1:0] modulus);
    logic [FRAC_W:0] frac_sum;
    frac_sum = {1'b0, frac_val} + {1'b0, inc};
    if (frac_sum >= {1'b0, modulus})
      return {int_val + INT_W'(1), FRAC_W'(frac_sum - {1'b0, modulus})};
    return {int_val, frac_sum[FRAC_W-1:0]};
  endfunction

  sweep_state_t      state;
  logic [CNT_W-1:0]  cnt;
  logic [INT_W-1:0]  lat_int;
  logic [FRAC_W-1:0] lat_frac;
  logic [FRAC_W-1:0] lat_step;
  logic [FRAC_W-1:0] lat_mod;
  logic [INT_W-1:0]  cur_int;
  logic [FRAC_W-1:0] cur_frac;
  logic              stop_pend;
  logic              wen_r;
  logic [31:0]       wdata_r;
  logic              lock_s;

  sync_2ff #(.DATA_W(1)) u_lock_sync (
    .CLK (CLK),
    .RST (RST),
    .d   (lock_det),
    .q   (lock_s)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= S_IDLE;
      cnt        <= '0;
      lat_int    <= '0;
      lat_frac   <= '0;
      lat_step   <= '0;
      lat_mod    <= '0;
      cur_int    <= '0;
      cur_frac   <= '0;
      stop_pend  <= 1'b0;
      wen_r      <= 1'b0;
      wdata_r    <= '0;
      dwell      <= 1'b0;
      step_idx   <= '0;
      lock_err   <= 1'b0;
      sweep_done <= 1'b0;
    end else begin
      wen_r      <= 1'b0;
      sweep_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start && !stop) begin
            lat_int   <= base_int;
            lat_frac  <= base_frac;
            lat_step  <= step_frac;
            lat_mod   <= mod;
            cur_int   <= base_int;
            cur_frac  <= base_frac;
            lock_err  <= 1'b0;
            step_idx  <= '0;
            stop_pend <= 1'b0;
            state     <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (stop) begin
            state <= S_IDLE;
          end else begin
            wdata_r <= reg0_word(cur_int, cur_frac);
            wen_r   <= 1'b1;
            state   <= S_WRITE;
          end
        end
        S_WRITE: begin
          if (stop) stop_pend <= 1'b1;
          state <= S_WAIT_DONE;
        end
        // An SPI transfer in flight is never cut short; a stop is held until done.
        S_WAIT_DONE: begin
          if (adf.adf_done) begin
            if (stop || stop_pend) begin
              stop_pend <= 1'b0;
              state     <= S_IDLE;
            end else begin
              cnt   <= SETTLE_LD;
              state <= S_SETTLE;
            end
          end else if (stop) begin
            stop_pend <= 1'b1;
          end
        end
        S_SETTLE: begin
          if (stop) begin
            state <= S_IDLE;
          end else if (cnt == '0) begin
            cnt   <= TIMEOUT_LD;
            state <= S_WAIT_LOCK;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        S_WAIT_LOCK: begin
          if (stop) begin
            state <= S_IDLE;
          end else if (lock_s) begin
            cnt   <= DWELL_LD;
            dwell <= 1'b1;
            state <= S_DWELL;
          end else if (cnt == '0) begin
            lock_err <= 1'b1;
            state    <= S_NEXT;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        S_DWELL: begin
          if (stop) begin
            dwell <= 1'b0;
            state <= S_IDLE;
          end else if (cnt == '0) begin
            dwell <= 1'b0;
            state <= S_NEXT;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        S_NEXT: begin
          if (stop) begin
            state <= S_IDLE;
          end else if (step_idx < LAST_IDX) begin
            {cur_int, cur_frac} <= next_freq(cur_int, cur_frac, lat_step, lat_mod);
            step_idx <= step_idx + IDX_W'(1);
            state    <= S_LOAD;
          end else begin
            sweep_done <= 1'b1;
            if (continuous) begin
              cur_int  <= lat_int;
              cur_frac <= lat_frac;
              step_idx <= '0;
              state    <= S_LOAD;
            end else begin
              {cur_int, cur_frac} <= next_freq(cur_int, cur_frac, lat_step, lat_mod);
              state <= S_IDLE;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy          = (state != S_IDLE);
  assign adf.adf_wen   = wen_r;
  assign adf.adf_wdata = wdata_r;

endmodule
